fifo_drain_ctrl: RTL and testbench

Read-side controller for the team's FIFO. It watches the FIFO status flags and issues read_enable. It captures the word the FIFO memory returns one cycle after each read and forwards it downstream with a valid strobe. It stalls when the downstream sink signals almost_full, and locks out on a FIFO error.

---
 rtl/fifo_drain_ctrl.sv | 152 +++++++++++++++
 tb/tb_fifo_drain_ctrl.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_drain_ctrl.sv
// -----------------------------------------------------------------------------
// fifo_drain_ctrl
// Read-side controller for the team FIFO. Watches the FIFO status flags and
// issues read_enable. Captures the word the FIFO memory returns one cycle after
// each read and forwards it downstream with a valid strobe. Stalls while the
// downstream sink is almost full, and locks out (sticky) on a FIFO error.
//
// Ports:
//   clk               in   rising-edge clock
//   reset             in   asynchronous, active-low
//   fifo_empty        in   FIFO empty flag
//   fifo_almost_empty in   FIFO almost-empty flag (status only)
//   fifo_error        in   FIFO error flag (count overflow)
//   fifo_data_out     in   FIFO read data, valid the cycle after read_enable
//   down_almost_full  in   downstream backpressure
//   read_enable       out  FIFO read strobe (combinational)
//   data_out          out  registered forwarded word
//   valid_out         out  registered, data_out valid this cycle
//   error_out         out  sticky error indication
//   state_out         out  current FSM state encoding
//   read_count        out  words delivered, saturating     (FIFO_DRAIN_COUNT_EN)
//   burst_len         out  length of last valid_out run     (FIFO_DRAIN_COUNT_EN)
//
// Optional feature macro: FIFO_DRAIN_COUNT_EN
// -----------------------------------------------------------------------------
module fifo_drain_ctrl #(
  parameter int unsigned TAMANO_DATOS     = 10,
  parameter int unsigned TAMANO_DIRECCION = 8
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    fifo_empty,
  input  logic                    fifo_almost_empty,
  input  logic                    fifo_error,
  input  logic [TAMANO_DATOS-1:0] fifo_data_out,
  input  logic                    down_almost_full,
  output logic                    read_enable,
  output logic [TAMANO_DATOS-1:0] data_out,
  output logic                    valid_out,
  output logic                    error_out,
  output logic [2:0]              state_out
`ifdef FIFO_DRAIN_COUNT_EN
  ,
  output logic [15:0]             read_count,
  output logic [7:0]              burst_len
`endif
);

  typedef enum logic [2:0] {
    ST_INIT   = 3'd0,
    ST_IDLE   = 3'd1,
    ST_ACTIVE = 3'd2,
    ST_PAUSE  = 3'd3,
    ST_ERROR  = 3'd4
  } state_e;

  // At most two reads are ever outstanding (one pending, one issuing), so the
  // FIFO must be at least that deep for the drain loop to be meaningful.
  localparam int unsigned InflightMax = 2;
  localparam bit          BudgetOk    = (TAMANO_DIRECCION >= InflightMax);

  state_e                  state_q, state_d;
  logic                    rd_pend_q;
  logic                    valid_q, valid_d;
  logic [TAMANO_DATOS-1:0] data_q;
  logic                    error_q;
  logic                    rd_en_c;
  logic                    cancel_c;

  // almost_empty is reported upstream only; it does not steer the drain.
  logic unused_status_c;
  assign unused_status_c = fifo_almost_empty;

  // Next-state and read strobe; priority is error, then backpressure, then empty.
  always_comb begin
    state_d = state_q;
    rd_en_c = 1'b0;
    case (state_q)
      ST_INIT: state_d = ST_IDLE;
      ST_IDLE: begin
        if (fifo_error)       state_d = ST_ERROR;
        else if (!fifo_empty) state_d = down_almost_full ? ST_PAUSE : ST_ACTIVE;
      end
      ST_ACTIVE: begin
        rd_en_c = !fifo_empty && !down_almost_full && !fifo_error && BudgetOk;
        if (fifo_error)            state_d = ST_ERROR;
        else if (down_almost_full) state_d = ST_PAUSE;
        else if (fifo_empty)       state_d = ST_IDLE;
      end
      ST_PAUSE: begin
        if (fifo_error)             state_d = ST_ERROR;
        else if (!down_almost_full) state_d = fifo_empty ? ST_IDLE : ST_ACTIVE;
      end
      ST_ERROR: state_d = ST_ERROR;
      default:  state_d = ST_INIT;
    endcase
  end

  // Entering ERROR drops the word still in flight so nothing is emitted there.
  assign cancel_c = (state_d == ST_ERROR);
  assign valid_d  = rd_pend_q && !cancel_c;

  // State, read pipeline and output registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= ST_INIT;
      rd_pend_q <= 1'b0;
      valid_q   <= 1'b0;
      data_q    <= '0;
      error_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      rd_pend_q <= rd_en_c && !cancel_c;
      valid_q   <= valid_d;
      if (valid_d) data_q <= fifo_data_out;
      if (state_q == ST_ERROR) error_q <= 1'b1;
    end
  end

  assign read_enable = rd_en_c;
  assign data_out    = data_q;
  assign valid_out   = valid_q;
  assign error_out   = error_q;
  assign state_out   = state_q;

`ifdef FIFO_DRAIN_COUNT_EN
  logic [15:0] count_q;
  logic [7:0]  run_q;
  logic [7:0]  burst_q;

  // Delivered-word counter and run-length capture on the falling valid edge.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count_q <= '0;
      run_q   <= '0;
      burst_q <= '0;
    end else begin
      if (valid_q && (count_q != 16'hFFFF)) count_q <= count_q + 16'd1;
      if (valid_q) begin
        if (run_q != 8'hFF) run_q <= run_q + 8'd1;
        if (!valid_d) burst_q <= (run_q == 8'hFF) ? 8'hFF : run_q + 8'd1;
      end else begin
        run_q <= '0;
      end
    end
  end

  assign read_count = count_q;
  assign burst_len  = burst_q;
`endif

endmodule

// File: tb/tb_fifo_drain_ctrl.sv
// -----------------------------------------------------------------------------
// tb_fifo_drain_ctrl
// Directed bench for fifo_drain_ctrl. A small queue models the FIFO (read data
// returned the cycle after read_enable) and a second queue holds the words
// expected downstream, in order.
// -----------------------------------------------------------------------------
module tb_fifo_drain_ctrl;

  localparam int unsigned DW = 10;
  localparam logic [2:0] S_INIT   = 3'd0;
  localparam logic [2:0] S_IDLE   = 3'd1;
  localparam logic [2:0] S_ACTIVE = 3'd2;
  localparam logic [2:0] S_PAUSE  = 3'd3;
  localparam logic [2:0] S_ERROR  = 3'd4;

  logic          clk;
  logic          reset;
  logic          fifo_empty;
  logic          fifo_almost_empty;
  logic          fifo_error;
  logic [DW-1:0] fifo_data_out;
  logic          down_almost_full;
  logic          read_enable;
  logic [DW-1:0] data_out;
  logic          valid_out;
  logic          error_out;
  logic [2:0]    state_out;
`ifdef FIFO_DRAIN_COUNT_EN
  logic [15:0]   read_count;
  logic [7:0]    burst_len;
`endif

  int            n_assert;
  int            n_fail;
  logic [DW-1:0] mem_q[$];
  logic [DW-1:0] exp_q[$];

  fifo_drain_ctrl #(.TAMANO_DATOS(DW), .TAMANO_DIRECCION(8)) dut (
    .clk              (clk),
    .reset            (reset),
    .fifo_empty       (fifo_empty),
    .fifo_almost_empty(fifo_almost_empty),
    .fifo_error       (fifo_error),
    .fifo_data_out    (fifo_data_out),
    .down_almost_full (down_almost_full),
    .read_enable      (read_enable),
    .data_out         (data_out),
    .valid_out        (valid_out),
    .error_out        (error_out),
    .state_out        (state_out)
`ifdef FIFO_DRAIN_COUNT_EN
    ,
    .read_count       (read_count),
    .burst_len        (burst_len)
`endif
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic push(input logic [DW-1:0] w);
    mem_q.push_back(w);
    exp_q.push_back(w);
    fifo_empty = 1'b0;
  endtask

  // Advance one clock: FIFO model answers the read, scoreboard checks output.
  task automatic cyc();
    logic re;
    #1;
    re = read_enable;
    if (re === 1'b1) chk("read_while_empty", 32'(fifo_empty), 32'd0);
    @(posedge clk);
    #1;
    if (re === 1'b1 && mem_q.size() > 0) fifo_data_out = mem_q.pop_front();
    fifo_empty = (mem_q.size() == 0);
    if (valid_out === 1'b1) begin
      if (exp_q.size() == 0) chk("valid_unexpected", 32'(valid_out), 32'd0);
      else                   chk("sb_data", 32'(data_out), 32'(exp_q.pop_front()));
    end
  endtask

  initial begin
    n_assert          = 0;
    n_fail            = 0;
    reset             = 1'b0;
    fifo_empty        = 1'b1;
    fifo_almost_empty = 1'b1;
    fifo_error        = 1'b0;
    fifo_data_out     = '0;
    down_almost_full  = 1'b0;

    // Reset values
    #2;
    chk("rst_state", 32'(state_out), 32'(S_INIT));
    chk("rst_valid", 32'(valid_out), 32'd0);
    chk("rst_data", 32'(data_out), 32'd0);
    chk("rst_error", 32'(error_out), 32'd0);
    chk("rst_re", 32'(read_enable), 32'd0);
`ifdef FIFO_DRAIN_COUNT_EN
    chk("rst_count", 32'(read_count), 32'd0);
`endif
    reset = 1'b1;

    // Idle with empty FIFO
    for (int i = 0; i < 10; i++) begin
      cyc(); #1;
      chk("idle_state", 32'(state_out), 32'(S_IDLE));
      chk("idle_re", 32'(read_enable), 32'd0);
      chk("idle_valid", 32'(valid_out), 32'd0);
    end

    // Single word
    push(10'h2A5); #1;
    chk("w1_re0", 32'(read_enable), 32'd0);
    cyc(); #1;
    chk("w1_state_act", 32'(state_out), 32'(S_ACTIVE));
    chk("w1_re1", 32'(read_enable), 32'd1);
    cyc(); #1;
    chk("w1_re2", 32'(read_enable), 32'd0);
    chk("w1_valid2", 32'(valid_out), 32'd0);
    cyc(); #1;
    chk("w1_valid3", 32'(valid_out), 32'd1);
    chk("w1_data3", 32'(data_out), 32'h2A5);
    chk("w1_state_idle", 32'(state_out), 32'(S_IDLE));
    cyc(); #1;
    chk("w1_valid4", 32'(valid_out), 32'd0);
    chk("w1_hold", 32'(data_out), 32'h2A5);
`ifdef FIFO_DRAIN_COUNT_EN
    chk("w1_count", 32'(read_count), 32'd1);
    chk("w1_burst", 32'(burst_len), 32'd1);
`endif

    // Burst of 8 words 0..7, no backpressure
    for (int w = 0; w < 8; w++) push(DW'(w));
    #1;
    chk("b8_state0", 32'(state_out), 32'(S_IDLE));
    for (int i = 1; i <= 12; i++) begin
      cyc(); #1;
      chk("b8_re", 32'(read_enable), 32'(i <= 8));
      chk("b8_state", 32'(state_out), 32'((i <= 9) ? S_ACTIVE : S_IDLE));
      chk("b8_valid", 32'(valid_out), 32'(i >= 3 && i <= 10));
    end
    chk("b8_all_delivered", 32'(exp_q.size()), 32'd0);
`ifdef FIFO_DRAIN_COUNT_EN
    chk("b8_count", 32'(read_count), 32'd9);
    chk("b8_burst", 32'(burst_len), 32'd8);
`endif

    // Backpressure after the 3rd read, released 5 cycles later
    for (int w = 0; w < 8; w++) push(DW'(10'h100 + w));
    #1;
    chk("bp_state0", 32'(state_out), 32'(S_IDLE));
    for (int i = 1; i <= 17; i++) begin
      cyc();
      down_almost_full = (i >= 4 && i <= 8);
      #1;
      chk("bp_re", 32'(read_enable), 32'((i <= 3) || (i >= 10 && i <= 14)));
      chk("bp_state", 32'(state_out),
          32'((i <= 4) ? S_ACTIVE : (i <= 9) ? S_PAUSE : (i <= 15) ? S_ACTIVE : S_IDLE));
      chk("bp_valid", 32'(valid_out), 32'((i >= 3 && i <= 5) || (i >= 12 && i <= 16)));
`ifdef FIFO_DRAIN_COUNT_EN
      if (i == 7) chk("bp_burst_first", 32'(burst_len), 32'd3);
`endif
    end
    chk("bp_all_delivered", 32'(exp_q.size()), 32'd0);
`ifdef FIFO_DRAIN_COUNT_EN
    chk("bp_count", 32'(read_count), 32'd17);
    chk("bp_burst", 32'(burst_len), 32'd5);
`endif

    // Error during ACTIVE: pending word cancelled, sticky error
    for (int w = 0; w < 6; w++) push(DW'(10'h200 + w));
    #1;
    chk("er_state0", 32'(state_out), 32'(S_IDLE));
    cyc(); #1;
    chk("er_re1", 32'(read_enable), 32'd1);
    cyc(); #1;
    chk("er_re2", 32'(read_enable), 32'd1);
    cyc();
    fifo_error = 1'b1;
    #1;
    chk("er_re3", 32'(read_enable), 32'd0);
    chk("er_state3", 32'(state_out), 32'(S_ACTIVE));
    chk("er_valid3", 32'(valid_out), 32'd1);
    cyc(); #1;
    chk("er_state_entry", 32'(state_out), 32'(S_ERROR));
    chk("er_valid_entry", 32'(valid_out), 32'd0);
    chk("er_errout_entry", 32'(error_out), 32'd0);
    chk("er_re_entry", 32'(read_enable), 32'd0);
    exp_q.delete();
    cyc(); #1;
    chk("er_errout", 32'(error_out), 32'd1);
    chk("er_valid5", 32'(valid_out), 32'd0);
    for (int i = 6; i <= 9; i++) begin
      cyc();
      fifo_error = 1'b0;
      #1;
      chk("er_sticky_state", 32'(state_out), 32'(S_ERROR));
      chk("er_sticky_err", 32'(error_out), 32'd1);
      chk("er_sticky_valid", 32'(valid_out), 32'd0);
      chk("er_sticky_re", 32'(read_enable), 32'd0);
`ifdef FIFO_DRAIN_COUNT_EN
      if (i == 6) begin
        chk("er_count", 32'(read_count), 32'd18);
        chk("er_burst", 32'(burst_len), 32'd1);
      end
`endif
    end

    // Async reset out of ERROR, between clock edges
    reset = 1'b0;
    #1;
    chk("ar1_state", 32'(state_out), 32'(S_INIT));
    chk("ar1_error", 32'(error_out), 32'd0);
    chk("ar1_data", 32'(data_out), 32'd0);
    chk("ar1_valid", 32'(valid_out), 32'd0);
    mem_q.delete();
    exp_q.delete();
    fifo_empty = 1'b1;
    reset = 1'b1;
    cyc(); #1;
    chk("ar1_idle", 32'(state_out), 32'(S_IDLE));

    // Async reset mid-burst
    for (int w = 0; w < 6; w++) push(DW'(10'h3C0 + w));
    for (int i = 1; i <= 4; i++) begin
      cyc(); #1;
      chk("ar2_valid", 32'(valid_out), 32'(i >= 3));
    end
    reset = 1'b0;
    #1;
    chk("ar2_state", 32'(state_out), 32'(S_INIT));
    chk("ar2_valid_rst", 32'(valid_out), 32'd0);
    chk("ar2_data_rst", 32'(data_out), 32'd0);
    chk("ar2_error_rst", 32'(error_out), 32'd0);
    chk("ar2_re_rst", 32'(read_enable), 32'd0);
`ifdef FIFO_DRAIN_COUNT_EN
    chk("ar2_count_rst", 32'(read_count), 32'd0);
`endif
    mem_q.delete();
    exp_q.delete();
    fifo_empty = 1'b1;
    reset = 1'b1;
    for (int i = 0; i < 4; i++) begin
      cyc(); #1;
      chk("ar2_no_complete", 32'(valid_out), 32'd0);
      chk("ar2_data_zero", 32'(data_out), 32'd0);
      chk("ar2_state_idle", 32'(state_out), 32'(S_IDLE));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
